// File: rtl/seg_display_scan.sv
// Scans four latched BCD digits onto a common-anode 7-segment display.
// It has a colon dot, a blink-on-hold mode and optional blanking of a leading zero in the minutes tens.
module seg_display_scan #(
  parameter int REFRESH_DIV = 2,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  input  logic       key,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [3:0]    shadow_reg [4];
  logic [3:0]    din [4];
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic          vis_reg, vis_next;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [3:0]    digit;

  assign din[0] = s1;
  assign din[1] = s2;
  assign din[2] = m1;
  assign din[3] = m2;

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end

    // Holding key low makes every update strobe flip the blink phase.
    if (key)
      vis_next = 1'b1;
    else if (upd)
      vis_next = ~vis_reg;
    else
      vis_next = vis_reg;

    digit    = shadow_reg[idx_reg];
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (vis_reg) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = decode(digit);
      if (BLANK_LZ && idx_reg == 2'd3 && digit == 4'd0)
        seg_next = 7'b1111111;
      dp_next  = (idx_reg != 2'd2);
    end
  end

  // The output is built from the state before the edge, so a fresh upd shows up one cycle later at the earliest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) shadow_reg[i] <= '0;
      cnt_reg <= '0;
      idx_reg <= '0;
      vis_reg <= 1'b1;
      an_reg  <= 4'b1111;
      seg_reg <= 7'b1111111;
      dp_reg  <= 1'b1;
    end else begin
      if (upd)
        for (int i = 0; i < 4; i++) shadow_reg[i] <= din[i];
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      vis_reg <= vis_next;
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan.
// It runs two instances side by side, one with leading-zero blanking and one without.
module tb_seg_display_scan;

  logic       clk;
  logic       reset;
  logic       upd;
  logic       key;
  logic [3:0] s1, s2, m1, m2;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  seg_display_scan #(.REFRESH_DIV(2), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .upd(upd), .key(key),
    .s1(s1), .s2(s2), .m1(m1), .m2(m2),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg_display_scan #(.REFRESH_DIV(2), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .upd(upd), .key(key),
    .s1(s1), .s2(s2), .m1(m1), .m2(m2),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_count = 0;
  int   err_count = 0;

  // Reference state of the display, advanced once per clock edge.
  logic [3:0] m_sh [4];
  int         m_cnt;
  int         m_idx;
  bit         m_vis;

  localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] model_out(input bit lz);
    logic [3:0] d;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    if (!m_vis) return BLANK;
    d = m_sh[m_idx];
    case (m_idx)
      0: an_e = 4'b1110;
      1: an_e = 4'b1101;
      2: an_e = 4'b1011;
      default: an_e = 4'b0111;
    endcase
    seg_e = ref_dec(d);
    if (lz && m_idx == 3 && d == 4'd0) seg_e = 7'b1111111;
    dp_e = (m_idx == 2) ? 1'b0 : 1'b1;
    return {an_e, seg_e, dp_e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    m_cnt = 0;
    m_idx = 0;
    m_vis = 1'b1;
    exp_q.delete();
  endtask

  // This task drives one cycle of inputs and pushes the expected output for the coming edge.
  // It then moves the model forward and waits until just after that edge.
  task automatic drive_cycle(input bit u, input bit k,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
    exp_t e;
    upd = u; key = k; s1 = a; s2 = b; m1 = c; m2 = d;
    e.a = model_out(1'b1);
    e.b = model_out(1'b0);
    exp_q.push_back(e);
    if (u) begin
      m_sh[0] = a; m_sh[1] = b; m_sh[2] = c; m_sh[3] = d;
    end
    if (m_cnt == 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (k) m_vis = 1'b1;
    else if (u) m_vis = ~m_vis;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; upd = 1'b0; key = 1'b1;
    s1 = 4'd0; s2 = 4'd0; m1 = 4'd0; m2 = 4'd0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      cmp_count++;
      if ({an_a, seg_a, dp_a} !== BLANK || {an_b, seg_b, dp_b} !== BLANK) begin
        $display("FAIL reset_blank: got %b/%b want %b", {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, BLANK);
        err_count++;
      end
    end
    reset = 1'b1;
    drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    e = exp_q.pop_front();
    cmp_count++;
    if ({an_a, seg_a, dp_a} !== e.a || {an_a, seg_a} !== {4'b1110, 7'b1000000}) begin
      $display("FAIL reset_first_digit: got %b want %b", {an_a, seg_a, dp_a}, e.a);
      err_count++;
    end
    $display("reset release: an=%b seg=%b dp=%b", an_a, seg_a, dp_a);
  endtask

  // Runs n cycles with fixed inputs; upd fires on cycles where (i % upd_every)==0 when upd_every > 0.
  task automatic test_run(input string name, input int n, input int upd_every, input bit k,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    exp_t e;
    bit   u;
    for (int i = 0; i < n; i++) begin
      u = (upd_every > 0) && (i % upd_every == 0);
      drive_cycle(u, k, a, b, c, d);
      if (exp_q.size() == 0) begin
        cmp_count++; err_count++;
        $display("FAIL %s_queue: got empty want 1 entry", name);
      end else begin
        e = exp_q.pop_front();
        cmp_count++;
        if ({an_a, seg_a, dp_a} !== e.a) begin
          $display("FAIL %s_lz1 cyc%0d: got %b want %b", name, i, {an_a, seg_a, dp_a}, e.a);
          err_count++;
        end
        cmp_count++;
        if ({an_b, seg_b, dp_b} !== e.b) begin
          $display("FAIL %s_lz0 cyc%0d: got %b want %b", name, i, {an_b, seg_b, dp_b}, e.b);
          err_count++;
        end
      end
      $display("%s cyc%0d upd=%0b key=%0b an=%b seg=%b dp=%b | an=%b seg=%b dp=%b",
               name, i, u, k, an_a, seg_a, dp_a, an_b, seg_b, dp_b);
    end
  endtask

  task automatic test_scan();
    test_run("scan_load", 1, 1, 1'b1, 4'd7, 4'd4, 4'd3, 4'd0);
    test_run("scan", 18, 0, 1'b1, 4'd7, 4'd4, 4'd3, 4'd0);
  endtask

  task automatic test_shadow_hold();
    test_run("hold", 8, 0, 1'b1, 4'd9, 4'd4, 4'd3, 4'd0);
    test_run("hold_upd", 10, 10, 1'b1, 4'd9, 4'd4, 4'd3, 4'd0);
  endtask

  task automatic test_blink();
    test_run("blink", 20, 4, 1'b0, 4'd9, 4'd4, 4'd3, 4'd0);
    test_run("key_run", 12, 4, 1'b1, 4'd9, 4'd4, 4'd3, 4'd0);
  endtask

  task automatic test_invalid();
    test_run("invalid", 10, 10, 1'b1, 4'hC, 4'd5, 4'd2, 4'd1);
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (!(m_idx == 2 && m_cnt == 1) && guard < 16) begin
      test_run("to_slot2", 1, 0, 1'b1, 4'hC, 4'd5, 4'd2, 4'd1);
      guard++;
    end
    cmp_count++;
    if (guard >= 16) begin
      $display("FAIL reach_slot2: got timeout want index 2");
      err_count++;
    end
    #2 reset = 1'b0;
    #1;
    cmp_count++;
    if ({an_a, seg_a, dp_a} !== BLANK) begin
      $display("FAIL async_reset: got %b want %b", {an_a, seg_a, dp_a}, BLANK);
      err_count++;
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    test_run("after_reset", 10, 0, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      test_run("b2b", 1, 1, 1'b1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)));
  endtask

  initial begin
    test_reset();
    test_scan();
    test_shadow_hold();
    test_blink();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
Consumer end of the clock's BCD digit interface. Takes the seconds digits (s1, s2) and minute digits (m1, m2) from the counters, and the 1-cycle update strobe from the seconds generator. Latches all four digits atomically, so no torn values are shown. Time-multiplexes them onto a common-anode 4-digit 7-segment display, with a colon dot, blink-on-hold and optional leading-zero blanking.

Parameters:
REFRESH_DIV, 2, clk cycles each digit slot is held (>=1)
BLANK_LZ, 1, 1 = blank m2 when m2==0

Ports:
clk  input  1  system clock (same clock as the seconds/minutes generators)
reset  input  1  asynchronous, active-low reset
upd  input  1  1-cycle strobe: digit inputs are valid/new this cycle (driven by seconds tick)
key  input  1  1 = run (steady display), 0 = hold/edit (display blinks)
s1  input  4  seconds units, BCD
s2  input  4  seconds tens, BCD
m1  input  4  minutes units, BCD
m2  input  4  minutes tens, BCD
an  output  4  digit anodes, active-low one-hot
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low (colon between minutes and seconds)

Behaviour:
- Reset (reset==0, async): an=4'b1111, seg=7'b1111111, dp=1, shadow digits=0, refresh count=0, scan index=0, vis=1.
- Shadow load: at a clk edge with upd==1, shadow{s1,s2,m1,m2} <= inputs, all four in the same edge. Otherwise hold. Inputs are ignored when upd==0.
- Refresh counter: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index increments 0->1->2->3->0.
- Output register: an/seg/dp are registered. Each edge they are computed from the current index and current shadow, i.e. the pre-edge values. Latency: an upd at edge N becomes visible at edge N+1 or later, once the index selects that digit.
- Index mapping: 0 -> an=1110, s1. 1 -> an=1101, s2. 2 -> an=1011, m1. 3 -> an=0111, m2.
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10..15 give 1111111, blank, with an still asserted.
- dp: 0 only when index==2 and vis==1; otherwise 1.
- Leading zero: BLANK_LZ==1, index==3 and shadow m2==0 -> seg=1111111. an is still driven; dp=1.
- Blink: on each upd with key==0, vis toggles. key==1 forces vis=1 at the next edge, regardless of upd. When vis==0: an=1111, seg=1111111, dp=1.
- Simultaneous upd and index wrap: both take effect on the same edge. The output for that edge uses the old shadow and the new index is shown from the next edge.
- Reset mid-scan: immediate blank outputs. After release, scanning restarts at index 0 and the shadow is 0 until the first upd.
- key transition mid-period: only sampled at edges. A key rise during vis==0 restores display on the next edge.

Test Plan:
1. Reset low for 3 cycles, then release with upd=0 -> during reset an=1111, seg=1111111, dp=1. First edge after release: an=1110, seg=1000000 (digit 0).
2. REFRESH_DIV=2, digits s1=7, s2=4, m1=3, m2=0, upd pulse once -> repeating an sequence 1110,1101,1011,0111, each held 2 cycles. seg=1111000, 0011001, 0110000, then 1111111 (m2 blanked). dp=0 only in the 1011 slot.
3. BLANK_LZ=0, m2=0 -> slot 0111 shows seg=1000000.
4. Change inputs to s1=9 with upd=0, then pulse upd -> seg stays 1111000 in slot 1110 until the pulse. Shows 0010000 on the first 1110 slot after the pulse edge.
5. key=0 with upd pulsed every 4 cycles -> an alternates between scanning and 1111 on each successive upd. Set key=1 -> scanning resumes on the next edge and never blanks.
6. s1=4'hC loaded -> slot 1110 shows seg=1111111. Assert reset mid-slot 2 -> outputs blank asynchronously; after release the index restarts at 0 with shadow=0.
